// File: rtl/shift_pipe_unit_pkg.sv
// Op encoding and decode helpers shared by the pipelined shifter and its stages.
package shift_pkg;

   typedef enum logic [2:0] {
      SH_SLL = 3'b000,
      SH_SRL = 3'b001,
      SH_SRA = 3'b011,
      SH_ROL = 3'b100,
      SH_ROR = 3'b101
   } shift_op_e;

   function automatic logic is_legal(logic [2:0] op);
      return (op == SH_SLL) || (op == SH_SRL) || (op == SH_SRA) ||
             (op == SH_ROL) || (op == SH_ROR);
   endfunction

   function automatic logic is_right(logic [2:0] op);
      return (op == SH_SRL) || (op == SH_SRA) || (op == SH_ROR);
   endfunction

   function automatic logic is_arith(logic [2:0] op);
      return op == SH_SRA;
   endfunction

   function automatic logic is_rotate(logic [2:0] op);
      return (op == SH_ROL) || (op == SH_ROR);
   endfunction

endpackage

// File: rtl/shift_pipe_unit_stage.sv
// One level of the barrel shifter: shifts by a fixed DIST when enabled.
// Rotate wrap-around is only built when SHIFT_ROTATE_EN is defined.
module shift_stage
   import shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DIST   = 1
) (
   input  logic [2:0]        op,
   input  logic              en,
   input  logic              sign,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DIST-1:0] left_fill;
   logic [DIST-1:0] right_fill;

   // Illegal ops are forced to zero here, so later stages just shift zeros.
   always_comb begin
      left_fill  = '0;
      right_fill = {DIST{is_arith(op) & sign}};
`ifdef SHIFT_ROTATE_EN
      if (is_rotate(op)) begin
         left_fill  = data_in[DATA_W-1 -: DIST];
         right_fill = data_in[DIST-1:0];
      end
`endif
      data_out = data_in;
      if (!is_legal(op)) begin
         data_out = '0;
      end else if (en) begin
         if (is_right(op)) begin
            data_out = {right_fill, data_in[DATA_W-1:DIST]};
         end else begin
            data_out = {data_in[DATA_W-1-DIST:0], left_fill};
         end
      end
   end

endmodule

// File: rtl/shift_pipe_unit.sv
// Pipelined barrel shifter with valid/ready flow control, one register per log2 level.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise they degrade to SLL/SRL.
module shift_pipe_unit
   import shift_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  TAG_W  = 5,
   localparam int SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SH_W-1:0]   in_shamt,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag
);

   logic [SH_W-1:0]   vld_q;
   logic [DATA_W-1:0] data_q  [SH_W];
   logic [TAG_W-1:0]  tag_q   [SH_W];
   logic [2:0]        op_q    [SH_W-1];
   logic [SH_W-1:0]   shamt_q [SH_W-1];
   logic [SH_W-2:0]   sign_q;

   logic [DATA_W-1:0] st_data_in  [SH_W];
   logic [DATA_W-1:0] st_data_out [SH_W];
   logic [2:0]        st_op       [SH_W];
   logic [SH_W-1:0]   st_shamt    [SH_W];
   logic [TAG_W-1:0]  st_tag      [SH_W];
   logic [SH_W-1:0]   st_sign;
   logic [SH_W-1:0]   st_vld;

   logic [SH_W:0]     rdy;
   logic              all_full;

   // Stage k consumes register k-1 (or the input port) and feeds register k.
   for (genvar k = 0; k < SH_W; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign st_data_in[k] = in_data;
         assign st_op[k]      = in_op;
         assign st_shamt[k]   = in_shamt;
         assign st_tag[k]     = in_tag;
         assign st_sign[k]    = in_data[DATA_W-1];
         assign st_vld[k]     = in_valid;
      end else begin : g_body
         assign st_data_in[k] = data_q[k-1];
         assign st_op[k]      = op_q[k-1];
         assign st_shamt[k]   = shamt_q[k-1];
         assign st_tag[k]     = tag_q[k-1];
         assign st_sign[k]    = sign_q[k-1];
         assign st_vld[k]     = vld_q[k-1];
      end

      shift_stage #(
         .DATA_W (DATA_W),
         .DIST   (1 << (SH_W-1-k))
      ) u_shift (
         .op       (st_op[k]),
         .en       (st_shamt[k][SH_W-1-k]),
         .sign     (st_sign[k]),
         .data_in  (st_data_in[k]),
         .data_out (st_data_out[k])
      );
   end

   // Unrolled ready chain: a stage can load if the consumer is ready or a bubble sits at or below it.
   always_comb begin
      all_full   = 1'b1;
      rdy        = '0;
      rdy[SH_W]  = out_ready;
      for (int k = SH_W-1; k >= 0; k--) begin
         all_full = all_full & vld_q[k];
         rdy[k]   = out_ready | ~all_full;
      end
   end

   // Pipeline registers; flush only kills valid bits, payload is don't-care once invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         sign_q <= '0;
         for (int k = 0; k < SH_W; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
         for (int k = 0; k < SH_W-1; k++) begin
            op_q[k]    <= '0;
            shamt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < SH_W; k++) begin
            if (flush) begin
               vld_q[k] <= 1'b0;
            end else if (rdy[k]) begin
               vld_q[k] <= st_vld[k];
            end
            if (rdy[k]) begin
               data_q[k] <= st_data_out[k];
               tag_q[k]  <= st_tag[k];
            end
         end
         for (int k = 0; k < SH_W-1; k++) begin
            if (rdy[k]) begin
               op_q[k]    <= st_op[k];
               shamt_q[k] <= st_shamt[k];
               sign_q[k]  <= st_sign[k];
            end
         end
      end
   end

   assign in_ready  = rdy[0] | flush;
   assign out_valid = vld_q[SH_W-1];
   assign out_data  = data_q[SH_W-1];
   assign out_tag   = tag_q[SH_W-1];

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Self-checking bench for shift_pipe_unit (DATA_W=32, TAG_W=5) against a queue-based reference.
// Expectations for ROL/ROR follow SHIFT_ROTATE_EN.
module tb_shift_pipe_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [2:0] op_pool [7] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b111};

   shift_pipe_unit #(.DATA_W(32), .TAG_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed no end of test, required finish before 1ms");
      $fatal(1);
   end

   // Reference: rotates are modelled as a doubled-word shift, SRA as signed arithmetic shift.
   function automatic logic [31:0] ref_shift(logic [2:0] op, logic [31:0] d, logic [4:0] sh);
      int          s;
      logic [63:0] dd;
      s  = int'(sh);
      dd = {d, d};
      case (op)
         3'b000: return d << s;
         3'b001: return d >> s;
         3'b011: return $signed(d) >>> s;
`ifdef SHIFT_ROTATE_EN
         3'b100: begin dd = dd << s; return dd[63:32]; end
         3'b101: begin dd = dd >> s; return dd[31:0]; end
`else
         3'b100: return d << s;
         3'b101: return d >> s;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   task automatic checkOutput(input logic consume);
      exp_t e;
      checkVal("output_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
         if (consume) e = exp_q.pop_front();
         else         e = exp_q[0];
         checkVal(consume ? "out_data" : "held_data", out_data, e.data);
         checkVal(consume ? "out_tag" : "held_tag", {27'b0, out_tag}, {27'b0, e.tag});
      end
   endtask

   // Drives one cycle of inputs at the negedge, scores the handshakes of the coming edge.
   task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] d,
                                input logic [4:0] sh, input logic [4:0] tg,
                                input logic ordy, input logic fl, output logic acc);
      in_valid  = v;
      in_op     = op;
      in_data   = d;
      in_shamt  = sh;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      #1;
      acc = 1'b0;
      if (fl) begin
         checkVal("flush_in_ready", {31'b0, in_ready}, 32'd1);
         exp_q.delete();
      end else begin
         if (out_valid) checkOutput(out_ready);
         if (in_valid && in_ready) begin
            acc = 1'b1;
            exp_q.push_back('{data: ref_shift(op, d, sh), tag: tg});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic acc;
      int   lat;
      int   nt;
      logic [31:0] rd;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'b0;
      in_data = '0; in_shamt = '0; in_tag = '0; out_ready = 1'b0;
      #2;
      checkVal("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkVal("reset_out_data", out_data, 32'd0);
      checkVal("reset_out_tag", {27'b0, out_tag}, 32'd0);
      checkVal("reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] latency: SLL 1 by 31");
      applyStimulus(1'b1, 3'b000, 32'h1, 5'd31, 5'd7, 1'b1, 1'b0, acc);
      checkVal("lat_accept", {31'b0, acc}, 32'd1);
      lat = 1;
      while (!out_valid && lat < 20) begin
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
         lat++;
      end
      checkVal("latency", lat, 32'd5);
      checkVal("lat_out_data", out_data, 32'h8000_0000);
      applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);

      $display("[TB] directed ops");
      applyStimulus(1'b1, 3'b011, 32'h8000_0000, 5'd4, 5'd1, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b001, 32'h8000_0000, 5'd4, 5'd2, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b011, 32'h7000_0000, 5'd4, 5'd3, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b101, 32'h0000_00F1, 5'd4, 5'd4, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b100, 32'h8000_0001, 5'd1, 5'd5, 1'b1, 1'b0, acc);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, op_pool[i], 32'hA5C3_0F96, 5'd0, 5'(8 + i), 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b111, 32'hDEAD_BEEF, 5'd0, 5'd13, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b111, 32'hDEAD_BEEF, 5'd9, 5'd14, 1'b1, 1'b0, acc);
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
      checkVal("directed_drained", exp_q.size(), 32'd0);

      $display("[TB] backpressure: 8 SLL ops");
      nt = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(nt < 8, 3'b000, $urandom, 5'($urandom_range(0, 31)), 5'(nt), 1'b0, 1'b0, acc);
         if (acc) nt++;
      end
      checkVal("bp_accepts", nt, 32'd5);
      checkVal("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkVal("bp_out_valid", {31'b0, out_valid}, 32'd1);
      for (int c = 0; c < 30; c++) begin
         if (nt < 8 || exp_q.size() != 0) begin
            applyStimulus(nt < 8, 3'b000, $urandom, 5'($urandom_range(0, 31)), 5'(nt), 1'b1, 1'b0, acc);
            if (acc) nt++;
         end
      end
      checkVal("bp_all_issued", nt, 32'd8);
      checkVal("bp_drained", exp_q.size(), 32'd0);

      $display("[TB] flush with 3 ops in flight");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 3'b001, 32'hFFFF_0000, 5'(i + 1), 5'(20 + i), 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 3'b000, 32'h1234_5678, 5'd3, 5'd23, 1'b1, 1'b1, acc);
      checkVal("flush_out_valid", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b1, 3'b011, 32'h9000_0000, 5'd2, 5'd24, 1'b1, 1'b0, acc);
      lat = 1;
      while (!out_valid && lat < 20) begin
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
         lat++;
      end
      checkVal("flush_new_latency", lat, 32'd5);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
      checkVal("flush_drained", exp_q.size(), 32'd0);

      $display("[TB] random traffic");
      for (int c = 0; c < 300; c++) begin
         rd = $urandom;
         applyStimulus($urandom_range(0, 3) != 0, op_pool[$urandom_range(0, 6)], rd,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       $urandom_range(0, 3) != 0, 1'b0, acc);
      end
      for (int c = 0; c < 12; c++)
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
      checkVal("random_drained", exp_q.size(), 32'd0);

      $display("[TB] asynchronous reset mid-stream");
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 3'b000, 32'hFFFF_FFFF, 5'd0, 5'(i + 1), 1'b0, 1'b0, acc);
      checkVal("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkVal("async_out_valid", {31'b0, out_valid}, 32'd0);
      checkVal("async_out_data", out_data, 32'd0);
      checkVal("async_out_tag", {27'b0, out_tag}, 32'd0);
      checkVal("async_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 3'b101, 32'h0000_00F1, 5'd4, 5'd30, 1'b1, 1'b0, acc);
      for (int c = 0; c < 8; c++)
         applyStimulus(1'b0, 3'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, acc);
      checkVal("post_reset_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
